// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester arbiter with fixed/round-robin mode select,
// grant locking while the owner keeps requesting, and a bounded hold limit
// that lets pending requesters preempt a long-running owner.
// Grants are registered and one-hot; there is no combinational r->g path.
module rr_arbiter_n #(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [N-1:0]  r,
  output logic [N-1:0]  g,
  output logic [IW-1:0] gidx,
  output logic          gvalid
);

  localparam int unsigned   HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IW-1:0] LAST_RST  = IW'(N - 1);
  localparam logic [N-1:0]  ONE       = N'(1);

  logic [N-1:0]  g_q, g_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic          gvalid_q, gvalid_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [IW-1:0] last_q, last_d;

  logic [N-1:0]  r_other;
  logic [N-1:0]  arb_req;
  logic          owner_req;
  logic          new_grant;
  logic [IW-1:0] win;

  // Select the winning index: lowest set bit in fixed mode, or the first set
  // bit after ptr (mod N) in round-robin mode.
  function automatic logic [IW-1:0] pick(input logic [N-1:0]  req,
                                         input logic          rr,
                                         input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic          found;
    int unsigned   j;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = rr ? (32'(ptr) + 32'd1 + i) % N : i;
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
    return idx;
  endfunction

  // Next-state: release/idle arbitration, hold-limit preemption, or hold.
  always_comb begin
    r_other    = r & ~g_q;
    owner_req  = |(r & g_q);
    g_d        = g_q;
    gidx_d     = gidx_q;
    gvalid_d   = gvalid_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    new_grant  = 1'b0;
    arb_req    = r;

    if (!gvalid_q || !owner_req) begin
      arb_req    = r;
      new_grant  = 1'b1;
      hold_cnt_d = '0;
    end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LAST && |r_other) begin
      arb_req    = r_other;
      new_grant  = 1'b1;
      hold_cnt_d = '0;
    end else if (MAX_HOLD != 0 && |r_other) begin
      if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      hold_cnt_d = '0;
    end

    win = pick(arb_req, mode, last_q);

    if (new_grant) begin
      if (|arb_req) begin
        g_d      = ONE << win;
        gidx_d   = win;
        gvalid_d = 1'b1;
        last_d   = win;
      end else begin
        g_d      = '0;
        gidx_d   = '0;
        gvalid_d = 1'b0;
      end
    end
  end

  // State registers; reset clears the grant immediately and points the
  // round-robin pointer at N-1 so index 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q        <= '0;
      gidx_q     <= '0;
      gvalid_q   <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= LAST_RST;
    end else begin
      g_q        <= g_d;
      gidx_q     <= gidx_d;
      gvalid_q   <= gvalid_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign g      = g_q;
  assign gidx   = gidx_q;
  assign gvalid = gvalid_q;

endmodule
